// File: rtl/vdg_pkg.sv
// Shared types and constants for the VDG character fetch/decode stage.
// Holds the cell geometry, mode encodings and the stage-1 / stage-2 record layouts.
package vdg_pkg;

  localparam int         ROWS_PER_CHAR = 12;
  localparam logic [3:0] ROW_LAST      = 4'(ROWS_PER_CHAR - 1);
  localparam logic [3:0] S4_SPLIT      = 4'd6;
  localparam logic [3:0] S6_SPLIT      = 4'd4;

  typedef enum logic [1:0] {
    MODE_ALPHA,
    MODE_SG4,
    MODE_SG6,
    MODE_GRAPH
  } mode_e;

  typedef enum logic {
    GREEN  = 1'b0,
    ORANGE = 1'b1
  } css_e;

  // Byte and mode pins captured on a preload strobe.
  typedef struct packed {
    logic [7:0] q;
    logic       inv;
    logic       ans;
    logic       ang;
    logic       css;
    logic       ext;
    logic [2:0] gm;
  } fetch_t;

  // Decoded record handed to the shift register and palette.
  typedef struct packed {
    logic [7:0] pix;
    logic [2:0] fg;
    logic       ang;
    logic       css;
    logic [2:0] gm;
  } video_t;

  function automatic mode_e mode_of(input logic ang, input logic ans, input logic ext);
    if (ang) return MODE_GRAPH;
    if (!ans) return MODE_ALPHA;
    return ext ? MODE_SG6 : MODE_SG4;
  endfunction

endpackage

// File: rtl/vdg_char_fetch_if.sv
// Bus between frame timing / display RAM and the fetch stage, plus the
// decoded output toward the shift register and the character-row lookup.
interface vdg_char_fetch_if;

  logic       preload;
  logic       hsn;
  logic       fsn;
  logic       rowclear;
  logic [7:0] q;
  logic       inv;
  logic       ans;
  logic       ang;
  logic       css;
  logic       ext;
  logic [2:0] gm;
  logic [5:0] char_index;
  logic [7:0] char_row;
  logic [3:0] alpha_row;
  logic [7:0] pix_byte;
  logic [2:0] fg_colour;
  logic       mode_ang;
  logic       mode_css;
  logic [2:0] mode_gm;
  logic       load_out;

  modport slave (
    input  preload, hsn, fsn, rowclear, q, inv, ans, ang, css, ext, gm, char_row,
    output char_index, alpha_row, pix_byte, fg_colour, mode_ang, mode_css, mode_gm, load_out
  );

  modport master (
    output preload, hsn, fsn, rowclear, q, inv, ans, ang, css, ext, gm, char_row,
    input  char_index, alpha_row, pix_byte, fg_colour, mode_ang, mode_css, mode_gm, load_out
  );

endinterface

// File: rtl/vdg_semigraphic_decode.sv
// Combinational SG4/SG6 block decoder: picks the left/right cell bits for the
// current character row and expands them to a half-byte each.
module vdg_semigraphic_decode
  import vdg_pkg::*;
(
  input  logic [7:0] q,
  input  logic [3:0] alpha_row,
  input  logic       css,
  input  logic       ext,
  output logic [7:0] pix_byte,
  output logic [2:0] fg_colour
);

  logic       left;
  logic       right;
  logic       upper;
  logic [3:0] sg6_block;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    left      = 1'b0;
    right     = 1'b0;
    upper     = alpha_row < S4_SPLIT;
    sg6_block = alpha_row / S6_SPLIT;
    fg_colour = q[6:4];
    if (!ext) begin
      left  = upper ? q[3] : q[1];
      right = upper ? q[2] : q[0];
    end else begin
      fg_colour = {css, q[7:6]};
      case (sg6_block)
        4'd0:    begin left = q[5]; right = q[4]; end
        4'd1:    begin left = q[3]; right = q[2]; end
        default: begin left = q[1]; right = q[0]; end
      endcase
    end
    pix_byte = {{4{left}}, {4{right}}};
  end

endmodule

// File: rtl/vdg_char_fetch.sv
// Two-stage fetch/decode between display RAM and the video shift register,
// plus the 0..11 alpha row counter driven by horizontal/field sync.
module vdg_char_fetch
  import vdg_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  vdg_char_fetch_if.slave  bus
);

  logic       hs_prev_q, hs_prev_d;
  logic [3:0] alpha_row_q, alpha_row_d;
  fetch_t     s1_q, s1_d;
  logic       s1_valid_q, s1_valid_d;
  video_t     out_q, out_d;
  logic       load_q, load_d;

  mode_e      mode;
  logic [7:0] sg_pix;
  logic [2:0] sg_fg;
  logic [7:0] dec_pix;
  logic [2:0] dec_fg;

  vdg_semigraphic_decode u_sg (
    .q         (s1_q.q),
    .alpha_row (alpha_row_q),
    .css       (s1_q.css),
    .ext       (s1_q.ext),
    .pix_byte  (sg_pix),
    .fg_colour (sg_fg)
  );

  // Clear sources are ordered: field sync low, then row preset, then the hsn rising edge.
  always_comb begin
    hs_prev_d   = bus.hsn;
    alpha_row_d = alpha_row_q;
    if (!bus.fsn || bus.rowclear) begin
      alpha_row_d = '0;
    end else if (!hs_prev_q && bus.hsn) begin
      alpha_row_d = (alpha_row_q == ROW_LAST) ? '0 : alpha_row_q + 4'd1;
    end
  end

  always_comb begin
    s1_valid_d = bus.preload;
    s1_d       = s1_q;
    if (bus.preload) begin
      s1_d.q   = bus.q;
      s1_d.inv = bus.inv;
      s1_d.ans = bus.ans;
      s1_d.ang = bus.ang;
      s1_d.css = bus.css;
      s1_d.ext = bus.ext;
      s1_d.gm  = bus.gm;
    end
  end

  // Decode sees the row counter as it stands one cycle after the strobe.
  always_comb begin
    mode    = mode_of(s1_q.ang, s1_q.ans, s1_q.ext);
    dec_pix = s1_q.q;
    dec_fg  = {2'b00, s1_q.css};
    case (mode)
      MODE_ALPHA: dec_pix = bus.char_row ^ {8{s1_q.inv}};
      MODE_SG4,
      MODE_SG6: begin
        dec_pix = sg_pix;
        dec_fg  = sg_fg;
      end
      default: ;
    endcase

    load_d = s1_valid_q;
    out_d  = out_q;
    if (s1_valid_q) begin
      out_d.pix = dec_pix;
      out_d.fg  = dec_fg;
      out_d.ang = s1_q.ang;
      out_d.css = s1_q.css;
      out_d.gm  = s1_q.gm;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_prev_q   <= 1'b0;
      alpha_row_q <= '0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      load_q      <= 1'b0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      alpha_row_q <= alpha_row_d;
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      load_q      <= load_d;
    end
  end

  assign bus.char_index = s1_q.q[5:0];
  assign bus.alpha_row  = alpha_row_q;
  assign bus.pix_byte   = out_q.pix;
  assign bus.fg_colour  = out_q.fg;
  assign bus.mode_ang   = out_q.ang;
  assign bus.mode_css   = out_q.css;
  assign bus.mode_gm    = out_q.gm;
  assign bus.load_out   = load_q;

endmodule

// File: tb/tb_vdg_char_fetch.sv
// Randomized + directed bench for vdg_char_fetch against a trace-based reference:
// fetches are queued with their due cycle and decoded from the recorded row history.
module tb_vdg_char_fetch;

  logic clk = 1'b0;
  logic resetn;

  vdg_char_fetch_if bus ();

  vdg_char_fetch dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_rom [64][16];
  always_comb bus.char_row = glyph_rom[bus.char_index][bus.alpha_row];

  typedef struct {
    int         due;
    logic [7:0] q;
    logic       inv, ans, ang, css, ext;
    logic [2:0] gm;
  } pend_t;

  pend_t      pend_q[$];
  logic [3:0] row_at [int];
  int         cyc;
  int         m_row;
  bit         m_hs_prev;
  logic [5:0] m_char_index;
  logic [7:0] m_pix;
  logic [2:0] m_fg;
  logic       m_ang, m_css, m_load;
  logic [2:0] m_gm;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_row        = 0;
    m_hs_prev    = 1'b0;
    m_char_index = '0;
    m_pix        = '0;
    m_fg         = '0;
    m_ang        = 1'b0;
    m_css        = 1'b0;
    m_gm         = '0;
    m_load       = 1'b0;
    pend_q.delete();
  endfunction

  // Returns {fg, pix} for a fetched byte shown on character row 'row'.
  function automatic logic [10:0] ref_decode(input pend_t p, input int row);
    logic [7:0] pix;
    logic [2:0] fg;
    bit         l, r;
    int         blk;
    l = 1'b0;
    r = 1'b0;
    if (p.ang) begin
      pix = p.q;
      fg  = {2'b00, p.css};
    end else if (!p.ans) begin
      pix = glyph_rom[p.q[5:0]][row] ^ (p.inv ? 8'hFF : 8'h00);
      fg  = {2'b00, p.css};
    end else begin
      if (!p.ext) begin
        l  = (row < 6) ? p.q[3] : p.q[1];
        r  = (row < 6) ? p.q[2] : p.q[0];
        fg = p.q[6:4];
      end else begin
        blk = row / 4;
        if (blk > 2) blk = 2;
        l  = p.q[5 - 2 * blk];
        r  = p.q[4 - 2 * blk];
        fg = {p.css, p.q[7:6]};
      end
      pix = (l ? 8'hF0 : 8'h00) | (r ? 8'h0F : 8'h00);
    end
    return {fg, pix};
  endfunction

  task automatic check_outputs();
    check("alpha_row",  32'(bus.alpha_row),  32'(m_row));
    check("char_index", 32'(bus.char_index), 32'(m_char_index));
    check("load_out",   32'(bus.load_out),   32'(m_load));
    check("pix_byte",   32'(bus.pix_byte),   32'(m_pix));
    check("fg_colour",  32'(bus.fg_colour),  32'(m_fg));
    check("mode_ang",   32'(bus.mode_ang),   32'(m_ang));
    check("mode_css",   32'(bus.mode_css),   32'(m_css));
    check("mode_gm",    32'(bus.mode_gm),    32'(m_gm));
  endtask

  // Advance one clock with the currently driven inputs, then compare.
  task automatic tick();
    pend_t      p;
    logic [10:0] d;
    if (!resetn) begin
      model_reset();
    end else begin
      if (bus.preload) begin
        p.due = cyc + 2;
        p.q   = bus.q;
        p.inv = bus.inv;
        p.ans = bus.ans;
        p.ang = bus.ang;
        p.css = bus.css;
        p.ext = bus.ext;
        p.gm  = bus.gm;
        pend_q.push_back(p);
        m_char_index = bus.q[5:0];
      end
      if (!bus.fsn || bus.rowclear) m_row = 0;
      else if (!m_hs_prev && bus.hsn) m_row = (m_row + 1) % 12;
      m_hs_prev = bus.hsn;
    end
    @(posedge clk);
    #1;
    cyc++;
    row_at[cyc] = 4'(m_row);
    m_load = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p      = pend_q.pop_front();
      d      = ref_decode(p, int'(row_at[cyc - 1]));
      m_pix  = d[7:0];
      m_fg   = d[10:8];
      m_ang  = p.ang;
      m_css  = p.css;
      m_gm   = p.gm;
      m_load = 1'b1;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_pix",   32'(bus.pix_byte),   32'h0);
    check("rst_fg",    32'(bus.fg_colour),  32'h0);
    check("rst_load",  32'(bus.load_out),   32'h0);
    check("rst_row",   32'(bus.alpha_row),  32'h0);
    check("rst_index", 32'(bus.char_index), 32'h0);
    check("rst_gm",    32'(bus.mode_gm),    32'h0);
    tick();
    tick();
    bus.preload = 1'b0;
    bus.hsn     = 1'b0;
    resetn      = 1'b1;
    tick();
    check("rst_no_load1", 32'(bus.load_out), 32'h0);
    tick();
    check("rst_no_load2", 32'(bus.load_out), 32'h0);
  endtask

  task automatic set_row(input int r);
    bus.rowclear = 1'b1;
    bus.hsn      = 1'b0;
    tick();
    bus.rowclear = 1'b0;
    repeat (r) begin
      bus.hsn = 1'b1;
      tick();
      bus.hsn = 1'b0;
      tick();
    end
  endtask

  task automatic fetch(input logic [7:0] qv, input logic inv_v, input logic ans_v,
                       input logic ang_v, input logic css_v, input logic ext_v);
    bus.q       = qv;
    bus.inv     = inv_v;
    bus.ans     = ans_v;
    bus.ang     = ang_v;
    bus.css     = css_v;
    bus.ext     = ext_v;
    bus.gm      = 3'($urandom_range(0, 7));
    bus.preload = 1'b1;
    tick();
    bus.preload = 1'b0;
    tick();
  endtask

  logic [7:0] gvals [4];

  initial begin
    for (int i = 0; i < 64; i++)
      for (int r = 0; r < 16; r++)
        glyph_rom[i][r] = 8'($urandom);
    for (int r = 0; r < 16; r++) glyph_rom[6'h15][r] = 8'h3C;

    cyc          = 0;
    resetn       = 1'b0;
    bus.preload  = 1'b0;
    bus.hsn      = 1'b0;
    bus.fsn      = 1'b1;
    bus.rowclear = 1'b0;
    bus.q        = '0;
    bus.inv      = 1'b0;
    bus.ans      = 1'b0;
    bus.ang      = 1'b0;
    bus.css      = 1'b0;
    bus.ext      = 1'b0;
    bus.gm       = '0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Row counter: 13 edges wrap through 0, rowclear beats an edge, fsn low holds 0.
    for (int i = 1; i <= 13; i++) begin
      bus.hsn = 1'b1;
      tick();
      check("row_edge", 32'(bus.alpha_row), 32'(i % 12));
      bus.hsn = 1'b0;
      tick();
    end
    bus.hsn      = 1'b1;
    bus.rowclear = 1'b1;
    tick();
    check("row_clear_edge", 32'(bus.alpha_row), 32'h0);
    bus.rowclear = 1'b0;
    bus.hsn      = 1'b0;
    tick();
    bus.fsn = 1'b0;
    repeat (3) begin
      bus.hsn = 1'b1;
      tick();
      check("row_fsn_hold", 32'(bus.alpha_row), 32'h0);
      bus.hsn = 1'b0;
      tick();
    end
    bus.fsn = 1'b1;

    // Alpha, inverted glyph.
    set_row(3);
    bus.q       = 8'h15;
    bus.inv     = 1'b1;
    bus.ans     = 1'b0;
    bus.ang     = 1'b0;
    bus.ext     = 1'b0;
    bus.css     = 1'b0;
    bus.preload = 1'b1;
    tick();
    check("alpha_index_n1", 32'(bus.char_index), 32'h15);
    check("alpha_load_n1",  32'(bus.load_out),   32'h0);
    bus.preload = 1'b0;
    tick();
    check("alpha_load_n2", 32'(bus.load_out), 32'h1);
    check("alpha_pix",     32'(bus.pix_byte), 32'hC3);

    // SG4 upper and lower halves.
    set_row(2);
    fetch(8'hB9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sg4_upper_pix", 32'(bus.pix_byte),  32'hF0);
    check("sg4_upper_fg",  32'(bus.fg_colour), 32'h3);
    set_row(7);
    fetch(8'hB9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sg4_lower_pix", 32'(bus.pix_byte),  32'h0F);

    // SG6 bottom and middle blocks.
    set_row(9);
    fetch(8'hC6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("sg6_bottom_pix", 32'(bus.pix_byte),  32'hF0);
    check("sg6_bottom_fg",  32'(bus.fg_colour), 32'h7);
    set_row(5);
    fetch(8'hC6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("sg6_mid_pix", 32'(bus.pix_byte), 32'h0F);

    // Graphics, back-to-back strobes.
    gvals   = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.ang = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.preload = (i < 4);
      if (i < 4) bus.q = gvals[i];
      tick();
      if (i >= 1 && i <= 4) begin
        check("b2b_load", 32'(bus.load_out), 32'h1);
        check("b2b_pix",  32'(bus.pix_byte), 32'(gvals[i - 1]));
      end
    end
    check("b2b_idle_load", 32'(bus.load_out), 32'h0);
    check("b2b_hold_pix",  32'(bus.pix_byte), 32'h44);

    // Reset with the pipeline full.
    bus.preload = 1'b1;
    bus.q       = 8'h5A;
    tick();
    tick();
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        bus.preload  = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 5) == 0) bus.hsn = ~bus.hsn;
        if (bus.fsn) bus.fsn = ($urandom_range(0, 99) != 0);
        else         bus.fsn = ($urandom_range(0, 3) == 0);
        bus.rowclear = ($urandom_range(0, 39) == 0);
        bus.q        = 8'($urandom);
        bus.inv      = 1'($urandom);
        bus.ans      = 1'($urandom);
        bus.ang      = ($urandom_range(0, 3) == 0);
        bus.css      = 1'($urandom);
        bus.ext      = 1'($urandom);
        bus.gm       = 3'($urandom);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vdg_char_fetch.md
Name: vdg_char_fetch

Overview:
- Fetch/decode stage between the display-RAM data bus and the video data shift register.
- On each preload strobe from frame timing it latches the RAM byte (Q) together with the mode pins, and maintains the 0..11 alpha row counter.
- It produces the 8-pixel byte, the foreground colour code and the latched mode for the shift register and palette stages.
- For text rows it obtains the glyph row from an external character-row lookup via char_index/char_row.

Parameters:
- ROWS_PER_CHAR, 12, character cell height; alpha row counter wraps at ROWS_PER_CHAR-1.
- S4_SPLIT, 6, first alpha row of the lower SG4 block.
- S6_SPLIT, 4, rows per SG6 block.

Ports:
- clk  in  1  video clock (NTSC pixel clock domain).
- resetn  in  1  asynchronous active-low reset.
- preload  in  1  one-cycle fetch strobe; q and the mode pins are valid in this cycle.
- hsn  in  1  horizontal sync, active low.
- fsn  in  1  field sync, active low.
- rowclear  in  1  one-cycle row-preset pulse (RP).
- q  in  8  display RAM data.
- inv, ans, ang, css, ext  in  1 each  mode pins, latched with q.
- gm  in  3  graphics mode, latched with q.
- char_index  out  6  glyph code to the external character-row lookup (combinational from the stage-1 register).
- char_row  in  8  glyph row returned combinationally for (char_index, alpha_row).
- alpha_row  out  4  current character row, 0..11.
- pix_byte  out  8  decoded pixels; MSB is the leftmost pixel.
- fg_colour  out  3  foreground colour code.
- mode_ang, mode_css  out  1 each  latched mode bits aligned with pix_byte.
- mode_gm  out  3  latched mode bits aligned with pix_byte.
- load_out  out  1  one-cycle strobe: pix_byte and its companions are new this cycle.

Behaviour:
- Reset (resetn=0, asynchronous): every register and output is 0, including alpha_row=0, load_out=0 and both pipeline stages. Release is synchronous to clk.
- Row counter, hsn edge:
  - The previous hsn is registered; an edge is hs_prev=0 and hsn=1.
  - Each edge increments alpha_row.
  - At ROWS_PER_CHAR-1 the counter wraps to 0.
- Row counter, clear conditions:
  - While fsn=0, alpha_row is held at 0.
  - rowclear=1 forces alpha_row to 0 on the next clock.
  - Priority: resetn > fsn low > rowclear > hsn edge.
- Stage 1, in the preload cycle N:
  - Register q, inv, ans, ang, css, ext and gm.
  - Set s1_valid.
  - char_index equals the registered q[5:0].
- Stage 2, cycle N+1: decode using the stage-1 registers and the alpha_row value at cycle N+1 (alpha_row is stable within a scan line). Decode by mode:
  - ang=1 (graphics): pix_byte=q; fg_colour={2'b00,css}.
  - ang=0, ans=0 (alpha): pix_byte=char_row, bitwise-inverted when inv=1; fg_colour={2'b00,css}. ext=1 selects the external glyph, but char_row is used either way.
  - ang=0, ans=1, ext=0 (SG4):
    - Quadrant bits q[3:0] are UL, UR, LL, LR.
    - Rows below S4_SPLIT use UL/UR; other rows use LL/LR.
    - pix_byte = {4{left}}, {4{right}}.
    - fg_colour=q[6:4].
  - ang=0, ans=1, ext=1 (SG6):
    - Cell bits q[5:0] are, from bit 5 down to bit 0, top L/R, mid L/R, bottom L/R.
    - Block = alpha_row / S6_SPLIT, range 0..2.
    - fg_colour={css,q[7:6]}.
- Stage-2 outputs: pix_byte, fg_colour and the mode_* outputs are registered. load_out=1 for exactly cycle N+2.
- Latency: preload at N → load_out at N+2.
- Back-to-back preload (every cycle) is fully pipelined: each strobe produces exactly one load_out, in order, with no loss.
- Outputs hold their last values between load_out strobes.
- preload while fsn=0 is still processed, with alpha_row=0.
- Reset asserted mid-pipeline discards in-flight data; no load_out follows the deassertion.
- If alpha_row changes between N and N+1 (preload coincident with an hsn edge), the N+1 value is used.

Decomposition:
- Shared package vdg_pkg holds:
  - mode encodings MODE_ALPHA, MODE_SG4, MODE_SG6, MODE_GRAPH;
  - ROWS_PER_CHAR;
  - colour code constants (GREEN=0, ORANGE=1 for css).
- One sub-module, vdg_semigraphic_decode: combinational; inputs q, alpha_row, css, ext; outputs pix_byte and fg_colour for SG4/SG6. The top holds the counter, pipeline and mode mux.

Test Plan:
- Reset: resetn low mid-stream with preload active → all outputs 0 immediately; no load_out for the 2 cycles after release.
- Row counter: 13 hsn rising edges with fsn=1 → alpha_row 1..11, 0, 1. Pulse rowclear in the same cycle as an edge → 0. Hold fsn=0 → alpha_row stays 0.
- Alpha: q=0x15, char_row=0x3C from model, inv=1 → char_index=0x15 at N+1; pix_byte=0xC3 with load_out at N+2.
- SG4: q=0xB9, alpha_row=2 → pix_byte=0xF0, fg_colour=3; alpha_row=7 → pix_byte=0x0F.
- SG6: q=0xC6, ext=1, css=1, alpha_row=9 → pix_byte=0xF0, fg_colour=7; alpha_row=5 → pix_byte=0x0F.
- Graphics, back-to-back: ang=1, preload for 4 consecutive cycles with q=0x11,0x22,0x33,0x44 → 4 consecutive load_out with those pix_byte values in order.
